// File: rtl/rs_encoder.sv
// Systematic RS(15,11) encoder over GF(16), poly x^4+x+1, g(x) roots a^1..a^4.
// Streams 11 message symbols through, then appends 4 parity symbols.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_sop     first message symbol of a codeword (qualified by in_valid)
//   in_valid   data_in holds a message symbol
//   data_in    message symbol (GF(16))
//   err_in     error pattern xored onto code_out (only with RS_ENC_ERR_INJECT_EN)
//   in_ready   symbol accepted when in_valid && in_ready
//   out_valid  code_out holds a codeword symbol (no backpressure)
//   code_out   registered codeword symbol, highest degree first
//   out_sop    message symbol 0 of a codeword
//   out_eop    parity symbol 3 of a codeword
//
// Build option: define RS_ENC_ERR_INJECT_EN to add the err_in port.
module rs_encoder (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_sop,
    input  logic       in_valid,
    input  logic [3:0] data_in,
`ifdef RS_ENC_ERR_INJECT_EN
    input  logic [3:0] err_in,
`endif
    output logic       in_ready,
    output logic       out_valid,
    output logic [3:0] code_out,
    output logic       out_sop,
    output logic       out_eop
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY
    } state_t;

    state_t           state;
    logic [3:0]       cnt;
    logic [3:0][3:0]  lfsr;

    logic             xfer;
    logic [3:0][3:0]  base;
    logic [3:0][3:0]  nxt;
    logic [3:0]       fb;
    logic [3:0]       emask;

    // GF(16) multiply, reduction by x^4 = x + 1
    function automatic logic [3:0] gf_mul(input logic [3:0] a,
                                          input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] x;
        p = 4'h0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

`ifdef RS_ENC_ERR_INJECT_EN
    assign emask = err_in;
`else
    assign emask = 4'h0;
`endif

    // A first symbol starts from a zero register, whatever state remains.
    always_comb begin
        xfer    = in_valid && in_ready;
        base    = in_sop ? '0 : lfsr;
        fb      = data_in ^ base[3];
        nxt[0]  = gf_mul(fb, 4'd7);
        nxt[1]  = base[0] ^ gf_mul(fb, 4'd8);
        nxt[2]  = base[1] ^ gf_mul(fb, 4'd12);
        nxt[3]  = base[2] ^ gf_mul(fb, 4'd13);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lfsr      <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            code_out  <= 4'h0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            unique case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (xfer && in_sop) begin
                        state     <= DATA;
                        cnt       <= 4'd1;
                        lfsr      <= nxt;
                        out_valid <= 1'b1;
                        out_sop   <= 1'b1;
                        code_out  <= data_in ^ emask;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        lfsr      <= nxt;
                        out_valid <= 1'b1;
                        out_sop   <= in_sop;
                        code_out  <= data_in ^ emask;
                        if (in_sop) begin
                            cnt <= 4'd1;
                        end else if (cnt == 4'd10) begin
                            state    <= PARITY;
                            cnt      <= 4'd0;
                            in_ready <= 1'b0;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    // Shift the remainder out, stage3 first.
                    out_valid <= 1'b1;
                    code_out  <= lfsr[3] ^ emask;
                    lfsr      <= {lfsr[2:0], 4'h0};
                    cnt       <= cnt + 4'd1;
                    if (cnt == 4'd3) begin
                        out_eop  <= 1'b1;
                        in_ready <= 1'b1;
                        state    <= IDLE;
                        cnt      <= 4'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
